countdown_timer: RTL

//  Loadable down-counter with start/done handshake; the counting-down

---
 rtl/counter_pkg.sv | 11 +
 rtl/countdown_timer.sv | 94 +++++++++
 2 files changed

// File: rtl/counter_pkg.sv
// Shared types for the counter family: the up-counter and the countdown timer
// use the same three-state sequencing enum.
package counter_pkg;

  typedef enum logic [1:0] {
    CD_IDLE = 2'd0,
    CD_RUN  = 2'd1,
    CD_DONE = 2'd2
  } cd_state_e;

endpackage : counter_pkg

// File: rtl/countdown_timer.sv
// Loadable down-counter with a start/done handshake. It captures a start value,
// decrements on enabled cycles and pulses done_o on reaching terminal count.
module countdown_timer
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [WIDTH-1:0] TERMINAL = WIDTH'(1);

  cd_state_e        state_r,  state_nxt;
  logic [WIDTH-1:0] count_r,  count_nxt;
  logic [WIDTH-1:0] reload_r, reload_nxt;
  logic             done_r,   done_nxt;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt  = state_r;
    count_nxt  = count_r;
    reload_nxt = reload_r;
    done_nxt   = 1'b0;

    if (abort) begin
      state_nxt = CD_IDLE;
      count_nxt = '0;
    end else begin
      unique case (state_r)
        CD_IDLE, CD_DONE: begin
          if (start && (load_val != '0)) begin
            state_nxt  = CD_RUN;
            count_nxt  = load_val;
            reload_nxt = load_val;
          end else if (start) begin
            // A zero load finishes immediately without any RUN cycles.
            state_nxt = CD_DONE;
            count_nxt = '0;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = CD_IDLE;
            count_nxt = '0;
          end
        end
        CD_RUN: begin
          if (en && (count_r == TERMINAL)) begin
            done_nxt = 1'b1;
            if (AUTO_RELOAD) begin
              count_nxt = reload_r;
            end else begin
              state_nxt = CD_DONE;
              count_nxt = '0;
            end
          end else if (en) begin
            count_nxt = count_r - TERMINAL;
          end
        end
        default: begin
          state_nxt = CD_IDLE;
          count_nxt = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled at the edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r  <= CD_IDLE;
      count_r  <= '0;
      reload_r <= '0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      count_r  <= count_nxt;
      reload_r <= reload_nxt;
      done_r   <= done_nxt;
    end
  end

  assign count_o = count_r;
  assign busy_o  = (state_r == CD_RUN);
  assign done_o  = done_r;

endmodule : countdown_timer
